// File: rtl/hyperbus_ctrl.sv
// HyperBus word-level transaction sequencer: CS#, 48-bit CA phase, initial latency,
// 16-bit data transfer and minimum CS# high time, one PHY word per hbus_clk.
module hyperbus_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 6,
  parameter int CSHI_CYC   = 2,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                  hbus_clk,
  input  logic                  hbus_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_adr,
  input  logic [7:0]            cmd_len,
  input  logic [15:0]           wr_dat,
  input  logic [1:0]            wr_be,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [15:0]           rd_dat,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  hb_cs_n,
  output logic [15:0]           hb_dq_o,
  output logic                  hb_dq_oe,
  output logic [1:0]            hb_rwds_o,
  output logic                  hb_rwds_oe,
  input  logic [15:0]           hb_dq_i,
  input  logic                  hb_dq_vld,
  input  logic                  hb_rwds_i
);

  // Handshakes: a command moves when cmd_valid & cmd_ready are both high at a rising
  // edge; a write word moves when wr_valid & wr_ready are both high at a rising edge;
  // rd_valid is a one-cycle strobe with no back-pressure.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CA    = 3'd1;
  localparam logic [2:0] S_LAT   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_CSHI  = 3'd5;

  localparam int LW = $clog2(2 * LATENCY + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int CW = (CSHI_CYC > 1) ? $clog2(CSHI_CYC) : 1;

  localparam logic [LW-1:0] LAT_SHORT = LW'(LATENCY - 1);
  localparam logic [LW-1:0] LAT_LONG  = LW'(2 * LATENCY - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] CSHI_LAST = CW'(CSHI_CYC - 1);

  logic [2:0]    state;
  logic          we_q;
  logic [47:0]   ca_q;
  logic [8:0]    rem;
  logic [1:0]    ca_cnt;
  logic [LW-1:0] lat_cnt;
  logic [TW-1:0] to_cnt;
  logic [CW-1:0] cshi_cnt;
  logic [31:0]   adr32;
  logic [47:0]   ca_w;

  generate
    if (ADDR_WIDTH >= 32) begin : g_adr_trunc
      assign adr32 = cmd_adr[31:0];
    end else begin : g_adr_ext
      assign adr32 = {{(32 - ADDR_WIDTH){1'b0}}, cmd_adr};
    end
  endgenerate

  // Read/write flag, memory space, linear burst, row/upper address, reserved, word-in-page.
  assign ca_w = {~cmd_we, 1'b0, 1'b1, adr32[31:3], 13'd0, adr32[2:0]};

  assign cmd_ready = (state == S_IDLE) & ~hbus_rst;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      ca_q       <= '0;
      rem        <= '0;
      ca_cnt     <= '0;
      lat_cnt    <= '0;
      to_cnt     <= '0;
      cshi_cnt   <= '0;
      hb_cs_n    <= 1'b1;
      hb_dq_o    <= '0;
      hb_dq_oe   <= 1'b0;
      hb_rwds_o  <= '0;
      hb_rwds_oe <= 1'b0;
      rd_valid   <= 1'b0;
      rd_dat     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      wr_ready   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            we_q     <= cmd_we;
            ca_q     <= ca_w;
            rem      <= {1'b0, cmd_len} + 9'd1;
            ca_cnt   <= 2'd0;
            hb_dq_o  <= ca_w[47:32];
            hb_cs_n  <= 1'b0;
            hb_dq_oe <= 1'b1;
            state    <= S_CA;
          end
        end
        S_CA: begin
          if (ca_cnt == 2'd0) begin
            hb_dq_o <= ca_q[31:16];
            ca_cnt  <= 2'd1;
          end else if (ca_cnt == 2'd1) begin
            hb_dq_o <= ca_q[15:0];
            ca_cnt  <= 2'd2;
          end else begin
            // RWDS high during CA means the device asks for doubled latency.
            hb_dq_o  <= '0;
            hb_dq_oe <= 1'b0;
            lat_cnt  <= hb_rwds_i ? LAT_LONG : LAT_SHORT;
            state    <= S_LAT;
          end
        end
        S_LAT: begin
          if (lat_cnt == '0) begin
            if (we_q) begin
              wr_ready <= 1'b1;
              state    <= S_WDATA;
            end else begin
              to_cnt <= '0;
              state  <= S_RDATA;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_WDATA: begin
          if (rem == 9'd0) begin
            // Last word has been on the bus for one cycle; close the burst.
            hb_cs_n    <= 1'b1;
            hb_dq_oe   <= 1'b0;
            hb_rwds_oe <= 1'b0;
            hb_dq_o    <= '0;
            hb_rwds_o  <= '0;
            done       <= 1'b1;
            cshi_cnt   <= CSHI_LAST;
            state      <= S_CSHI;
          end else if (wr_valid) begin
            hb_dq_o    <= wr_dat;
            hb_rwds_o  <= ~wr_be;
            hb_dq_oe   <= 1'b1;
            hb_rwds_oe <= 1'b1;
            rem        <= rem - 9'd1;
            if (rem == 9'd1) wr_ready <= 1'b0;
          end else begin
            hb_cs_n    <= 1'b1;
            hb_dq_oe   <= 1'b0;
            hb_rwds_oe <= 1'b0;
            hb_dq_o    <= '0;
            hb_rwds_o  <= '0;
            wr_ready   <= 1'b0;
            err        <= 1'b1;
            cshi_cnt   <= CSHI_LAST;
            state      <= S_CSHI;
          end
        end
        S_RDATA: begin
          if (hb_dq_vld) begin
            rd_dat   <= hb_dq_i;
            rd_valid <= 1'b1;
            rem      <= rem - 9'd1;
            to_cnt   <= '0;
            if (rem == 9'd1) begin
              done     <= 1'b1;
              hb_cs_n  <= 1'b1;
              cshi_cnt <= CSHI_LAST;
              state    <= S_CSHI;
            end
          end else if (to_cnt == TO_LAST) begin
            err      <= 1'b1;
            hb_cs_n  <= 1'b1;
            cshi_cnt <= CSHI_LAST;
            state    <= S_CSHI;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_CSHI: begin
          if (cshi_cnt == '0) state <= S_IDLE;
          else                cshi_cnt <= cshi_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Directed bench for hyperbus_ctrl: CA encoding, latency select, read/write bursts,
// aborts, timeout, reset mid-transaction and back-to-back commands.
module tb_hyperbus_ctrl;

  logic        hbus_clk = 1'b0;
  logic        hbus_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [7:0]  cmd_len;
  logic [15:0] wr_dat;
  logic [1:0]  wr_be;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_dat;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic        hb_cs_n;
  logic [15:0] hb_dq_o;
  logic        hb_dq_oe;
  logic [1:0]  hb_rwds_o;
  logic        hb_rwds_oe;
  logic [15:0] hb_dq_i;
  logic        hb_dq_vld;
  logic        hb_rwds_i;

  int errors = 0;
  int checks = 0;

  hyperbus_ctrl #(
    .ADDR_WIDTH(32), .LATENCY(6), .CSHI_CYC(2), .RD_TIMEOUT(64)
  ) dut (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_dat(wr_dat), .wr_be(wr_be), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_dat(rd_dat), .rd_valid(rd_valid),
    .busy(busy), .done(done), .err(err),
    .hb_cs_n(hb_cs_n), .hb_dq_o(hb_dq_o), .hb_dq_oe(hb_dq_oe),
    .hb_rwds_o(hb_rwds_o), .hb_rwds_oe(hb_rwds_oe),
    .hb_dq_i(hb_dq_i), .hb_dq_vld(hb_dq_vld), .hb_rwds_i(hb_rwds_i)
  );

  // clock / reset
  always #5 hbus_clk = ~hbus_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge hbus_clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [7:0] len);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    hbus_rst  = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
    wr_dat = '0; wr_be = '0; wr_valid = 1'b0;
    hb_dq_i = '0; hb_dq_vld = 1'b0; hb_rwds_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({hb_cs_n, hb_dq_oe, hb_rwds_oe, rd_valid, done, err, wr_ready, busy, cmd_ready} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 100000000",
               {hb_cs_n, hb_dq_oe, hb_rwds_oe, rd_valid, done, err, wr_ready, busy, cmd_ready});
    end
    checks++;
    if ({hb_dq_o, rd_dat, hb_rwds_o} !== 34'd0) begin
      errors++;
      $display("FAIL reset_data: dq_o=%h rd_dat=%h rwds_o=%b expected zeros", hb_dq_o, rd_dat, hb_rwds_o);
    end
    hbus_rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_read_basic;
    logic [15:0] exp_q[$];
    logic [15:0] words [4];
    logic [15:0] exp;
    int n_rd;
    words[0] = 16'h1001; words[1] = 16'h2002; words[2] = 16'h3003; words[3] = 16'h4004;
    hb_rwds_i = 1'b0;
    issue(1'b0, 32'h0000_1235, 8'd3);
    checks++;
    if ({hb_cs_n, hb_dq_oe, hb_dq_o} !== {1'b0, 1'b1, 16'hA000}) begin
      errors++;
      $display("FAIL rd_ca0: cs_n=%b oe=%b dq=%h expected 0 1 a000", hb_cs_n, hb_dq_oe, hb_dq_o);
    end
    tick();
    checks++;
    if (hb_dq_o !== 16'h0246) begin
      errors++;
      $display("FAIL rd_ca1: got %h expected 0246", hb_dq_o);
    end
    tick();
    checks++;
    if (hb_dq_o !== 16'h0005) begin
      errors++;
      $display("FAIL rd_ca2: got %h expected 0005", hb_dq_o);
    end
    tick();
    checks++;
    if ({hb_cs_n, hb_dq_oe, hb_rwds_oe} !== 3'b000) begin
      errors++;
      $display("FAIL rd_lat_bus: got %b expected 000", {hb_cs_n, hb_dq_oe, hb_rwds_oe});
    end
    // PHY noise during latency must be ignored
    hb_dq_vld = 1'b1;
    hb_dq_i   = 16'hDEAD;
    n_rd = 0;
    repeat (6) begin
      tick();
      if (rd_valid) n_rd++;
    end
    checks++;
    if (n_rd !== 0) begin
      errors++;
      $display("FAIL rd_lat_ignore: got %0d strobes expected 0", n_rd);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);
    for (int i = 0; i < 4; i++) begin
      hb_dq_i   = words[i];
      hb_dq_vld = 1'b1;
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({rd_valid, rd_dat} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL rd_word%0d: valid=%b dat=%h expected 1 %h", i, rd_valid, rd_dat, exp);
      end
      checks++;
      if (done !== (i == 3)) begin
        errors++;
        $display("FAIL rd_done%0d: got %b expected %b", i, done, (i == 3));
      end
    end
    hb_dq_vld = 1'b0;
    checks++;
    if ({hb_cs_n, cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rd_cshi1: cs_n=%b ready=%b expected 1 0", hb_cs_n, cmd_ready);
    end
    tick();
    checks++;
    if ({hb_cs_n, cmd_ready, rd_valid, done} !== 4'b1000) begin
      errors++;
      $display("FAIL rd_cshi2: got %b expected 1000", {hb_cs_n, cmd_ready, rd_valid, done});
    end
    tick();
    checks++;
    if ({hb_cs_n, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rd_idle: cs_n=%b ready=%b expected 1 1", hb_cs_n, cmd_ready);
    end
  endtask

  task automatic test_write_basic;
    int n;
    int nrdy;
    issue(1'b1, 32'h0000_0010, 8'd1);
    checks++;
    if (hb_dq_o !== 16'h2000) begin
      errors++;
      $display("FAIL wr_ca0: got %h expected 2000", hb_dq_o);
    end
    tick();
    checks++;
    if (hb_dq_o !== 16'h0002) begin
      errors++;
      $display("FAIL wr_ca1: got %h expected 0002", hb_dq_o);
    end
    tick();
    checks++;
    if (hb_dq_o !== 16'h0000) begin
      errors++;
      $display("FAIL wr_ca2: got %h expected 0000", hb_dq_o);
    end
    tick();
    wr_valid = 1'b1; wr_dat = 16'h1111; wr_be = 2'b11;
    n = 0;
    while (!wr_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL wr_lat_cycles: got %0d expected 6", n);
    end
    nrdy = wr_ready ? 1 : 0;
    tick();
    if (wr_ready) nrdy++;
    checks++;
    if ({hb_dq_o, hb_rwds_o, hb_dq_oe, hb_rwds_oe} !== {16'h1111, 2'b00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wr_word0: dq=%h rwds=%b oe=%b%b expected 1111 00 11",
               hb_dq_o, hb_rwds_o, hb_dq_oe, hb_rwds_oe);
    end
    wr_dat = 16'h2222; wr_be = 2'b01;
    tick();
    if (wr_ready) nrdy++;
    checks++;
    if ({hb_dq_o, hb_rwds_o, hb_cs_n, done} !== {16'h2222, 2'b10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wr_word1: dq=%h rwds=%b cs_n=%b done=%b expected 2222 10 0 0",
               hb_dq_o, hb_rwds_o, hb_cs_n, done);
    end
    tick();
    if (wr_ready) nrdy++;
    checks++;
    if ({done, hb_cs_n, hb_dq_oe, hb_rwds_oe, err} !== 5'b11000) begin
      errors++;
      $display("FAIL wr_done: got %b expected 11000", {done, hb_cs_n, hb_dq_oe, hb_rwds_oe, err});
    end
    wr_valid = 1'b0;
    checks++;
    if (nrdy !== 2) begin
      errors++;
      $display("FAIL wr_ready_cycles: got %0d expected 2", nrdy);
    end
    wait_idle(n);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_back_idle: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_long_latency;
    int k;
    int n;
    logic got;
    hb_rwds_i = 1'b0;
    issue(1'b0, 32'h0, 8'd0);
    k = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      tick();
      k++;
      if (rd_valid) got = 1'b1;
      else begin
        hb_dq_i   = 16'(k);
        hb_dq_vld = (k >= 3);
        hb_rwds_i = (k == 2);
      end
    end
    hb_dq_vld = 1'b0;
    hb_rwds_i = 1'b0;
    checks++;
    if (k !== 16) begin
      errors++;
      $display("FAIL lat2x_cycles: first strobe at %0d expected 16", k);
    end
    checks++;
    if ({rd_dat, done} !== {16'd15, 1'b1}) begin
      errors++;
      $display("FAIL lat2x_data: dat=%h done=%b expected 000f 1", rd_dat, done);
    end
    wait_idle(n);
  endtask

  task automatic test_write_abort;
    int n;
    int consumed;
    int n_done;
    int n_err;
    issue(1'b1, 32'h0000_0040, 8'd3);
    wr_valid = 1'b1; wr_dat = 16'hAAA1; wr_be = 2'b11;
    n = 0;
    while (!wr_ready && n < 40) begin
      tick();
      n++;
    end
    consumed = (wr_ready && wr_valid) ? 1 : 0;
    tick();
    wr_dat = 16'hAAA2;
    checks++;
    if (hb_dq_o !== 16'hAAA1) begin
      errors++;
      $display("FAIL ab_word0: got %h expected aaa1", hb_dq_o);
    end
    if (wr_ready && wr_valid) consumed++;
    tick();
    checks++;
    if ({hb_dq_o, wr_ready, hb_cs_n} !== {16'hAAA2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ab_word1: dq=%h rdy=%b cs_n=%b expected aaa2 1 0", hb_dq_o, wr_ready, hb_cs_n);
    end
    wr_valid = 1'b0;
    tick();
    checks++;
    if ({hb_cs_n, err, done, hb_dq_oe, hb_rwds_oe, wr_ready} !== 6'b110000) begin
      errors++;
      $display("FAIL ab_abort: got %b expected 110000", {hb_cs_n, err, done, hb_dq_oe, hb_rwds_oe, wr_ready});
    end
    checks++;
    if (consumed !== 2) begin
      errors++;
      $display("FAIL ab_consumed: got %0d expected 2", consumed);
    end
    n = 0; n_done = 0; n_err = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
      if (done) n_done++;
      if (err) n_err++;
    end
    checks++;
    if ({n_done, n_err} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL ab_pulses: done=%0d err=%0d after abort expected 0 0", n_done, n_err);
    end
  endtask

  task automatic test_read_timeout;
    int n;
    int extra;
    issue(1'b0, 32'h0000_0100, 8'd1);
    repeat (9) tick();
    hb_dq_vld = 1'b1;
    hb_dq_i   = 16'h5A5A;
    tick();
    hb_dq_vld = 1'b0;
    checks++;
    if ({rd_valid, rd_dat, done} !== {1'b1, 16'h5A5A, 1'b0}) begin
      errors++;
      $display("FAIL to_word0: valid=%b dat=%h done=%b expected 1 5a5a 0", rd_valid, rd_dat, done);
    end
    n = 0; extra = 0;
    while (!err && n < 200) begin
      tick();
      n++;
      if (rd_valid || done) extra++;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL to_cycles: err after %0d cycles expected 64", n);
    end
    checks++;
    if ({hb_cs_n, extra} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL to_close: cs_n=%b extra=%0d expected 1 0", hb_cs_n, extra);
    end
    wait_idle(n);
  endtask

  task automatic test_reset_mid;
    int n;
    issue(1'b0, 32'h0, 8'd0);
    repeat (4) tick();
    hbus_rst = 1'b1;
    #1;
    checks++;
    if ({hb_cs_n, hb_dq_oe, hb_rwds_oe, cmd_ready, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL rst_mid: got %b expected 10000", {hb_cs_n, hb_dq_oe, hb_rwds_oe, cmd_ready, busy});
    end
    tick();
    hbus_rst = 1'b0;
    #1;
    checks++;
    if ({done, err, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst_release: done=%b err=%b ready=%b expected 0 0 1", done, err, cmd_ready);
    end
    issue(1'b0, 32'h0000_0008, 8'd0);
    checks++;
    if (hb_dq_o !== 16'hA000) begin
      errors++;
      $display("FAIL rst_ca0: got %h expected a000", hb_dq_o);
    end
    tick();
    checks++;
    if (hb_dq_o !== 16'h0001) begin
      errors++;
      $display("FAIL rst_ca1: got %h expected 0001", hb_dq_o);
    end
    repeat (8) tick();
    hb_dq_vld = 1'b1;
    hb_dq_i   = 16'hBEEF;
    tick();
    hb_dq_vld = 1'b0;
    checks++;
    if ({rd_valid, rd_dat, done} !== {1'b1, 16'hBEEF, 1'b1}) begin
      errors++;
      $display("FAIL rst_read: valid=%b dat=%h done=%b expected 1 beef 1", rd_valid, rd_dat, done);
    end
    wait_idle(n);
  endtask

  task automatic test_back_to_back;
    int hi;
    int n;
    cmd_we = 1'b0; cmd_adr = 32'h0; cmd_len = 8'd0; cmd_valid = 1'b1;
    tick();
    repeat (9) tick();
    hb_dq_vld = 1'b1;
    hb_dq_i   = 16'h1234;
    tick();
    hb_dq_vld = 1'b0;
    checks++;
    if ({done, rd_dat} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL b2b_first: done=%b dat=%h expected 1 1234", done, rd_dat);
    end
    hi = hb_cs_n ? 1 : 0;
    while (hb_cs_n && hi < 20) begin
      tick();
      if (hb_cs_n) hi++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (hi !== 3) begin
      errors++;
      $display("FAIL b2b_cs_high: got %0d cycles expected 3", hi);
    end
    repeat (9) tick();
    hb_dq_vld = 1'b1;
    hb_dq_i   = 16'h5678;
    tick();
    hb_dq_vld = 1'b0;
    checks++;
    if ({done, rd_valid, rd_dat} !== {1'b1, 1'b1, 16'h5678}) begin
      errors++;
      $display("FAIL b2b_second: done=%b valid=%b dat=%h expected 1 1 5678", done, rd_valid, rd_dat);
    end
    wait_idle(n);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got %b expected 1", cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_long_latency();
    test_write_abort();
    test_read_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
